// File: rtl/chip_seq_pkg.sv
// rtl/chip_seq_pkg.sv - shared opcodes, FSM states and default widths for the chip sequencer
package chip_seq_pkg;

  localparam int ADDR_W_DEF   = 8;
  localparam int SEED_W_DEF   = 8;
  localparam int OUT_W_DEF    = 4;
  localparam int R8_BEATS_DEF = 2;
  localparam int WR_PULSE_DEF = 4;
  localparam int READ_LAT_DEF = 2;
  localparam int LEN_W_DEF    = 16;

  typedef enum logic [2:0] {
    OP_WRITE    = 3'd0,
    OP_SEED     = 3'd1,
    OP_LOAD_MEM = 3'd2,
    OP_INFER    = 3'd3,
    OP_READ1    = 3'd4,
    OP_READ8    = 3'd5
  } op_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    PULSE  = 3'd2,
    RUN    = 3'd3,
    SAMPLE = 3'd4,
    RESP   = 3'd5
  } state_e;

  // Opcodes above OP_READ8 have no chip action and are answered with an error.
  function automatic logic op_illegal(input logic [2:0] op);
    return op > 3'd5;
  endfunction

endpackage

// File: rtl/chip_seq_ctrl_if.sv
// rtl/chip_seq_ctrl_if.sv - command and response channels of the chip sequencer
interface chip_seq_ctrl_if #(
  parameter int ADDR_W   = 8,
  parameter int SEED_W   = 8,
  parameter int OUT_W    = 4,
  parameter int R8_BEATS = 2,
  parameter int LEN_W    = 16
);

  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [2:0]                cmd_op;
  logic [ADDR_W-1:0]         cmd_row;
  logic [ADDR_W-1:0]         cmd_col;
  logic [SEED_W-1:0]         cmd_data;
  logic [LEN_W-1:0]          cmd_len;
  logic                      cmd_stoch;

  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [OUT_W*R8_BEATS-1:0] rsp_data;
  logic                      rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_row, cmd_col, cmd_data, cmd_len, cmd_stoch, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_row, cmd_col, cmd_data, cmd_len, cmd_stoch, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/chip_seq_timer.sv
// rtl/chip_seq_timer.sv - loadable down-counter that stops at zero
module chip_seq_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count;

  // Load wins over counting; the count parks at zero instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/chip_seq_ctrl.sv
// rtl/chip_seq_ctrl.sv - command sequencer driving the inference array chip port (optional CHIP_SEQ_STAT_EN statistics)
module chip_seq_ctrl
  import chip_seq_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int SEED_W   = SEED_W_DEF,
  parameter int OUT_W    = OUT_W_DEF,
  parameter int R8_BEATS = R8_BEATS_DEF,
  parameter int WR_PULSE = WR_PULSE_DEF,
  parameter int READ_LAT = READ_LAT_DEF,
  parameter int LEN_W    = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  chip_seq_ctrl_if.slave    bus,
  output logic              CBL,
  output logic              CBLEN,
  output logic              CWL,
  output logic              inference,
  output logic              load_seed,
  output logic              read_1,
  output logic              read_8,
  output logic              load_mem,
  output logic              read_out,
  output logic              stoch_log,
  output logic [ADDR_W-1:0] addr_full_row,
  output logic [ADDR_W-1:0] addr_full_col,
  output logic [SEED_W-1:0] seeds,
  input  logic [OUT_W-1:0]  bit_out
`ifdef CHIP_SEQ_STAT_EN
  ,
  output logic [15:0]       stat_cmd_cnt,
  output logic              stat_err
`endif
);

  localparam int RSP_W  = OUT_W * R8_BEATS;
  localparam int PH_W   = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam int BEAT_W = $clog2(R8_BEATS + 1);

  localparam logic [LEN_W-1:0] PULSE_LD = LEN_W'(WR_PULSE - 1);
  localparam logic [LEN_W-1:0] RD1_LD   = LEN_W'(READ_LAT - 1);
  localparam logic [LEN_W-1:0] RD8_LD   = LEN_W'(R8_BEATS * READ_LAT - 1);
  localparam logic [PH_W-1:0]  PH_LD    = PH_W'(READ_LAT - 1);

  state_e             state;
  state_e             state_nxt;
  logic [2:0]         op_q;
  logic               wr_bit_q;
  logic               stoch_q;
  logic               tail;
  logic [RSP_W-1:0]   rsp_data_q;
  logic               rsp_err_q;
  logic [PH_W-1:0]    ph;
  logic [BEAT_W-1:0]  beat;
  logic               accept;
  logic               tmr_load;
  logic [LEN_W-1:0]   tmr_val;
  logic               tmr_en;
  logic               tmr_zero;

  assign bus.cmd_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign tmr_en        = (state == PULSE) || (state == RUN) || (state == SAMPLE);

  chip_seq_timer #(.W(LEN_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and timer reload; the timer is loaded with (cycles - 1) on state entry.
  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          case (bus.cmd_op)
            OP_WRITE, OP_SEED, OP_LOAD_MEM: state_nxt = SETUP;
            OP_INFER: begin
              state_nxt = RUN;
              tmr_load  = 1'b1;
              tmr_val   = (bus.cmd_len == '0) ? '0 : bus.cmd_len - LEN_W'(1);
            end
            OP_READ1: begin
              state_nxt = SAMPLE;
              tmr_load  = 1'b1;
              tmr_val   = RD1_LD;
            end
            OP_READ8: begin
              state_nxt = SAMPLE;
              tmr_load  = 1'b1;
              tmr_val   = RD8_LD;
            end
            default: state_nxt = RESP;
          endcase
        end
      end
      SETUP: begin
        // A write passes SETUP twice: once before the CWL pulse and once as the hold after it.
        if ((op_q == OP_WRITE) && !tail) begin
          state_nxt = PULSE;
          tmr_load  = 1'b1;
          tmr_val   = PULSE_LD;
        end else begin
          state_nxt = IDLE;
        end
      end
      PULSE: begin
        if (tmr_zero) state_nxt = SETUP;
      end
      RUN: begin
        if (tmr_zero) begin
          state_nxt = SAMPLE;
          tmr_load  = 1'b1;
          tmr_val   = RD1_LD;
        end
      end
      SAMPLE: begin
        if (tmr_zero) state_nxt = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Chip strobes decoded from state and latched opcode; all low in IDLE and RESP.
  always_comb begin
    CBL       = 1'b0;
    CBLEN     = 1'b0;
    CWL       = 1'b0;
    inference = 1'b0;
    load_seed = 1'b0;
    read_1    = 1'b0;
    read_8    = 1'b0;
    load_mem  = 1'b0;
    read_out  = 1'b0;
    stoch_log = 1'b0;
    case (state)
      SETUP: begin
        case (op_q)
          OP_WRITE: begin
            CBLEN = 1'b1;
            CBL   = wr_bit_q;
          end
          OP_SEED:     load_seed = 1'b1;
          OP_LOAD_MEM: load_mem  = 1'b1;
          default: ;
        endcase
      end
      PULSE: begin
        CWL   = 1'b1;
        CBLEN = 1'b1;
        CBL   = wr_bit_q;
      end
      RUN: begin
        inference = 1'b1;
        stoch_log = stoch_q;
      end
      SAMPLE: begin
        case (op_q)
          OP_INFER: read_out = 1'b1;
          OP_READ1: read_1   = 1'b1;
          OP_READ8: read_8   = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Command latch, seed bus, write-hold flag and result capture every READ_LAT cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q          <= '0;
      wr_bit_q      <= 1'b0;
      stoch_q       <= 1'b0;
      tail          <= 1'b0;
      addr_full_row <= '0;
      addr_full_col <= '0;
      seeds         <= '0;
      rsp_data_q    <= '0;
      rsp_err_q     <= 1'b0;
      ph            <= '0;
      beat          <= '0;
    end else begin
      if (accept) begin
        op_q          <= bus.cmd_op;
        wr_bit_q      <= bus.cmd_data[0];
        stoch_q       <= bus.cmd_stoch;
        tail          <= 1'b0;
        addr_full_row <= bus.cmd_row;
        addr_full_col <= bus.cmd_col;
        rsp_data_q    <= '0;
        rsp_err_q     <= op_illegal(bus.cmd_op);
        ph            <= PH_LD;
        beat          <= '0;
        if (bus.cmd_op == OP_SEED) seeds <= bus.cmd_data;
      end
      if ((state == PULSE) && tmr_zero) tail <= 1'b1;
      if (state == SAMPLE) begin
        if (ph == '0) begin
          rsp_data_q[int'(beat)*OUT_W +: OUT_W] <= bit_out;
          beat <= beat + BEAT_W'(1);
          ph   <= PH_LD;
        end else begin
          ph <= ph - PH_W'(1);
        end
      end
    end
  end

`ifdef CHIP_SEQ_STAT_EN
  // Saturating accepted-command count and sticky error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_cmd_cnt <= '0;
      stat_err     <= 1'b0;
    end else begin
      if (accept && (stat_cmd_cnt != 16'hFFFF)) stat_cmd_cnt <= stat_cmd_cnt + 16'd1;
      if (rsp_err_q) stat_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_chip_seq_ctrl.sv
// tb/tb_chip_seq_ctrl.sv - randomized scoreboard bench for chip_seq_ctrl
module tb_chip_seq_ctrl;
  import chip_seq_pkg::*;

  localparam int ADDR_W = 8;
  localparam int SEED_W = 8;
  localparam int OUT_W  = 4;
  localparam int R8     = 2;
  localparam int WP     = 4;
  localparam int RL     = 2;
  localparam int LEN_W  = 16;
  localparam int RSP_W  = OUT_W * R8;
  localparam int BOUND  = 500;

  typedef struct packed {
    logic [RSP_W-1:0] d;
    logic             e;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  chip_seq_ctrl_if #(.ADDR_W(ADDR_W), .SEED_W(SEED_W), .OUT_W(OUT_W), .R8_BEATS(R8), .LEN_W(LEN_W)) bus ();

  logic CBL, CBLEN, CWL, inference, load_seed, read_1, read_8, load_mem, read_out, stoch_log;
  logic [ADDR_W-1:0] addr_full_row, addr_full_col;
  logic [SEED_W-1:0] seeds;
  logic [OUT_W-1:0]  bit_out;
`ifdef CHIP_SEQ_STAT_EN
  logic [15:0] stat_cmd_cnt;
  logic        stat_err;
`endif

  chip_seq_ctrl #(
    .ADDR_W(ADDR_W), .SEED_W(SEED_W), .OUT_W(OUT_W), .R8_BEATS(R8),
    .WR_PULSE(WP), .READ_LAT(RL), .LEN_W(LEN_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .CBL           (CBL),
    .CBLEN         (CBLEN),
    .CWL           (CWL),
    .inference     (inference),
    .load_seed     (load_seed),
    .read_1        (read_1),
    .read_8        (read_8),
    .load_mem      (load_mem),
    .read_out      (read_out),
    .stoch_log     (stoch_log),
    .addr_full_row (addr_full_row),
    .addr_full_col (addr_full_col),
    .seeds         (seeds),
    .bit_out       (bit_out)
`ifdef CHIP_SEQ_STAT_EN
    ,
    .stat_cmd_cnt  (stat_cmd_cnt),
    .stat_err      (stat_err)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Strobe cycle counters, indexed by svec bit.
  logic [9:0] svec;
  assign svec = {read_8, read_1, read_out, stoch_log, inference, load_mem, load_seed, CBL, CWL, CBLEN};
  string sname[10] = '{"CBLEN", "CWL", "CBL", "load_seed", "load_mem", "inference", "stoch_log", "read_out", "read_1", "read_8"};
  int scnt[10];

  always @(negedge clk) begin
    int excl;
    if (rst_n) begin
      for (int i = 0; i < 10; i++) if (svec[i]) scnt[i]++;
      excl = int'(load_seed) + int'(load_mem) + int'(read_1) + int'(read_8) + int'(inference) + int'(read_out) + int'(CWL);
      if (excl > 0) check("strobe_exclusive", (excl <= 1), 1);
    end
  end

  // Chip model: the valid result appears only on the last cycle of each READ_LAT beat, its complement otherwise.
  logic [OUT_W-1:0] beats[R8];
  int rk = 0;
  always @(negedge clk) begin
    if (read_out || read_1 || read_8) begin
      if ((rk / RL) < R8) begin
        if ((rk % RL) == RL - 1) bit_out = beats[rk / RL];
        else                     bit_out = ~beats[rk / RL];
      end else begin
        bit_out = OUT_W'($urandom);
      end
      rk++;
    end else begin
      rk = 0;
      bit_out = OUT_W'($urandom);
    end
  end

  // Scoreboard monitor with randomized response backpressure.
  rsp_t exp_q[$];
  int   next_stall = -1;
  int   stall = 0;
  bit   in_rsp = 1'b0;
  logic [RSP_W-1:0] hold_d;
  logic             hold_e;

  always @(negedge clk) begin
    rsp_t e;
    if (!rst_n) begin
      bus.rsp_ready = 1'b0;
      in_rsp = 1'b0;
    end else if (bus.rsp_valid) begin
      if (!in_rsp) begin
        in_rsp = 1'b1;
        hold_d = bus.rsp_data;
        hold_e = bus.rsp_err;
        if (next_stall >= 0) begin
          stall = next_stall;
          next_stall = -1;
        end else begin
          stall = $urandom_range(0, 5);
        end
      end else begin
        check("rsp_data_stable", bus.rsp_data, hold_d);
        check("rsp_err_stable", bus.rsp_err, hold_e);
      end
      check("cmd_ready_during_rsp", bus.cmd_ready, 0);
      if (stall > 0) begin
        stall--;
        bus.rsp_ready = 1'b0;
      end else begin
        bus.rsp_ready = 1'b1;
        in_rsp = 1'b0;
        check("rsp_expected", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("rsp_data", bus.rsp_data, e.d);
          check("rsp_err", bus.rsp_err, e.e);
        end
      end
    end else begin
      bus.rsp_ready = 1'b0;
      in_rsp = 1'b0;
    end
  end

  // Reference state kept by the bench.
  logic [SEED_W-1:0] seeds_m = '0;
  logic [ADDR_W-1:0] row_m = '0, col_m = '0;
  int n_acc = 0;
  bit err_m = 1'b0;

  task automatic send_cmd(input logic [2:0] op, input logic [7:0] r, input logic [7:0] c,
                          input logic [7:0] d, input logic [15:0] len, input logic st);
    int t;
    @(negedge clk);
    for (int i = 0; i < 10; i++) scnt[i] = 0;
    bus.cmd_op = op; bus.cmd_row = r; bus.cmd_col = c; bus.cmd_data = d;
    bus.cmd_len = len; bus.cmd_stoch = st; bus.cmd_valid = 1'b1;
    t = 0;
    while (!bus.cmd_ready && t < BOUND) begin
      @(negedge clk);
      t++;
    end
    check("cmd_accept_timeout", (t < BOUND), 1);
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    n_acc++;
    row_m = r;
    col_m = c;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!bus.cmd_ready && t < BOUND) begin
      @(negedge clk);
      t++;
    end
    check("idle_timeout", (t < BOUND), 1);
  endtask

  task automatic issue(input logic [2:0] op, input logic [7:0] r, input logic [7:0] c,
                       input logic [7:0] d, input logic [15:0] len, input logic st,
                       input logic [3:0] b0, input logic [3:0] b1);
    int   exp[10];
    int   eff;
    rsp_t e;
    for (int i = 0; i < 10; i++) exp[i] = 0;
    beats[0] = b0;
    beats[1] = b1;
    eff = (len == 0) ? 1 : int'(len);
    e.d = '0;
    e.e = 1'b0;
    case (op)
      3'd0: begin exp[0] = WP + 2; exp[1] = WP; exp[2] = d[0] ? WP + 2 : 0; end
      3'd1: begin exp[3] = 1; seeds_m = d; end
      3'd2: exp[4] = 1;
      3'd3: begin
        exp[5] = eff; exp[6] = st ? eff : 0; exp[7] = RL;
        e.d = RSP_W'(b0); exp_q.push_back(e);
      end
      3'd4: begin exp[8] = RL; e.d = RSP_W'(b0); exp_q.push_back(e); end
      3'd5: begin
        exp[9] = R8 * RL;
        for (int i = 0; i < R8; i++) e.d = e.d | (RSP_W'(beats[i]) << (i * OUT_W));
        exp_q.push_back(e);
      end
      default: begin e.e = 1'b1; exp_q.push_back(e); err_m = 1'b1; end
    endcase
    send_cmd(op, r, c, d, len, st);
    wait_idle();
    for (int i = 0; i < 10; i++) check(sname[i], scnt[i], exp[i]);
    check("seeds", seeds, seeds_m);
    check("addr_row", addr_full_row, row_m);
    check("addr_col", addr_full_col, col_m);
`ifdef CHIP_SEQ_STAT_EN
    check("stat_cmd_cnt", stat_cmd_cnt, n_acc);
    check("stat_err", stat_err, err_m);
`endif
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_row = '0; bus.cmd_col = '0;
    bus.cmd_data = '0; bus.cmd_len = '0; bus.cmd_stoch = 1'b0;
    beats[0] = '0; beats[1] = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_strobes", svec, 0);
    check("reset_addr", {addr_full_row, addr_full_col}, 0);
    check("reset_seeds", seeds, 0);
    check("reset_rsp_valid", bus.rsp_valid, 0);
    check("reset_rsp_data", bus.rsp_data, 0);
    check("reset_rsp_err", bus.rsp_err, 0);
    check("reset_cmd_ready", bus.cmd_ready, 1);

    issue(OP_WRITE, 8'h12, 8'h34, 8'h01, 16'd0, 1'b0, 4'h0, 4'h0);
    issue(OP_SEED, 8'h00, 8'h00, 8'hA5, 16'd0, 1'b0, 4'h0, 4'h0);
    issue(OP_INFER, 8'h01, 8'h02, 8'h00, 16'd5, 1'b1, 4'h9, 4'h0);
    next_stall = 4;
    issue(OP_READ8, 8'h05, 8'h06, 8'h00, 16'd0, 1'b0, 4'h3, 4'hC);
    issue(3'd7, 8'h07, 8'h08, 8'hFF, 16'd0, 1'b0, 4'h0, 4'h0);
    issue(OP_INFER, 8'h09, 8'h0A, 8'h00, 16'd0, 1'b0, 4'h6, 4'h0);
    issue(OP_LOAD_MEM, 8'hAB, 8'hCD, 8'h00, 16'd0, 1'b0, 4'h0, 4'h0);

    // Reset in the middle of an inference run.
    send_cmd(OP_INFER, 8'h11, 8'h22, 8'h00, 16'd30, 1'b0);
    repeat (6) @(negedge clk);
    check("midrun_inference", inference, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrun_reset_strobes", svec, 0);
    check("midrun_reset_rsp_valid", bus.rsp_valid, 0);
    check("midrun_reset_addr", {addr_full_row, addr_full_col}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrun_cmd_ready", bus.cmd_ready, 1);
    check("midrun_rsp_valid", bus.rsp_valid, 0);
    seeds_m = '0; row_m = '0; col_m = '0; n_acc = 0; err_m = 1'b0;

    for (int n = 0; n < 60; n++) begin
      logic [2:0]  op;
      logic [15:0] len;
      op  = 3'($urandom_range(0, 7));
      len = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 40));
      issue(op, 8'($urandom), 8'($urandom), 8'($urandom), len, 1'($urandom),
            4'($urandom), 4'($urandom));
    end

    repeat (3) @(negedge clk);
    check("rsp_queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
